// File: rtl/pixel_window_gen.sv
// rtl/pixel_window_gen.sv - streaming 3x3 binary window generator with two-row line buffers
// Raster-order pixels in, one registered 3x3 neighbourhood per handshake out on X_0..X_8.
module pixel_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_in,
  input  logic pix_valid,
  output logic pix_ready,
  output logic X_0,
  output logic X_1,
  output logic X_2,
  output logic X_3,
  output logic X_4,
  output logic X_5,
  output logic X_6,
  output logic X_7,
  output logic X_8,
  output logic win_valid,
  input  logic win_ready,
  output logic frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {
    S_FILL,
    S_STREAM
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [IMG_W-1:0] r_lb0;
  logic [IMG_W-1:0] r_lb1;
  logic [8:0]      r_win;
  logic            r_win_valid;
  logic            r_frame_done;

  logic w_accept;
  logic w_handoff;
  logic w_col_last;
  logic w_row_last;
  logic w_frame_last;
  logic w_emit;

  assign pix_ready    = !r_win_valid || win_ready;
  assign w_accept     = pix_valid && pix_ready;
  assign w_handoff    = r_win_valid && win_ready;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_frame_last = w_col_last && w_row_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // STREAM implies row >= 2, so only the column test is left for emission
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept && (r_row == RW'(1)) && w_col_last) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        w_emit = w_accept && (r_col >= CW'(2));
        if (w_accept && w_frame_last) begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lb0 <= '0;
      r_lb1 <= '0;
    end else if (w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= pix_in;
    end
  end

  // r_win[k] is X_k; each row shifts left and takes the new column on its right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (w_accept) begin
      r_win <= {pix_in, r_win[8:7], r_lb1[r_col], r_win[5:4], r_lb0[r_col], r_win[2:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_emit) begin
        r_win_valid <= 1'b1;
      end else if (w_handoff) begin
        r_win_valid <= 1'b0;
      end
      r_frame_done <= w_accept && w_frame_last;
    end
  end

  assign X_0        = r_win[0];
  assign X_1        = r_win[1];
  assign X_2        = r_win[2];
  assign X_3        = r_win[3];
  assign X_4        = r_win[4];
  assign X_5        = r_win[5];
  assign X_6        = r_win[6];
  assign X_7        = r_win[7];
  assign X_8        = r_win[8];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_window_gen.sv
// tb/tb_pixel_window_gen.sv - bench for pixel_window_gen on 4x4, 8x8 and 3x3 instances
// Expected windows are cut straight out of the source image array for every interior position.
module tb_pixel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] pin;
  logic [2:0] pv;
  logic [2:0] wr;
  logic [2:0] pr;
  logic [2:0] wv;
  logic [2:0] fd;
  logic [8:0] x4;
  logic [8:0] x8;
  logic [8:0] x3;

  int         sel;
  logic [8:0] s_x;
  logic       s_pr;
  logic       s_wv;
  logic       s_fd;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_window_gen #(.IMG_W(4), .IMG_H(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .pix_in(pin[0]), .pix_valid(pv[0]), .pix_ready(pr[0]),
    .X_0(x4[0]), .X_1(x4[1]), .X_2(x4[2]), .X_3(x4[3]), .X_4(x4[4]),
    .X_5(x4[5]), .X_6(x4[6]), .X_7(x4[7]), .X_8(x4[8]),
    .win_valid(wv[0]), .win_ready(wr[0]), .frame_done(fd[0])
  );

  pixel_window_gen #(.IMG_W(8), .IMG_H(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .pix_in(pin[1]), .pix_valid(pv[1]), .pix_ready(pr[1]),
    .X_0(x8[0]), .X_1(x8[1]), .X_2(x8[2]), .X_3(x8[3]), .X_4(x8[4]),
    .X_5(x8[5]), .X_6(x8[6]), .X_7(x8[7]), .X_8(x8[8]),
    .win_valid(wv[1]), .win_ready(wr[1]), .frame_done(fd[1])
  );

  pixel_window_gen #(.IMG_W(3), .IMG_H(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .pix_in(pin[2]), .pix_valid(pv[2]), .pix_ready(pr[2]),
    .X_0(x3[0]), .X_1(x3[1]), .X_2(x3[2]), .X_3(x3[3]), .X_4(x3[4]),
    .X_5(x3[5]), .X_6(x3[6]), .X_7(x3[7]), .X_8(x3[8]),
    .win_valid(wv[2]), .win_ready(wr[2]), .frame_done(fd[2])
  );

  always_comb begin
    s_x  = x4;
    s_pr = pr[0];
    s_wv = wv[0];
    s_fd = fd[0];
    case (sel)
      1: begin s_x = x8; s_pr = pr[1]; s_wv = wv[1]; s_fd = fd[1]; end
      2: begin s_x = x3; s_pr = pr[2]; s_wv = wv[2]; s_fd = fd[2]; end
      default: begin end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int s);
    sel = s;
    #1;
    check("rst_x", 32'(s_x), 32'd0);
    check("rst_win_valid", 32'(s_wv), 32'd0);
    check("rst_frame_done", 32'(s_fd), 32'd0);
    check("rst_pix_ready", 32'(s_pr), 32'd1);
  endtask

  // mode 0: continuous, 1: pix_valid toggling, 2: random valid and random ready
  task automatic run_frame(input int s, input int w, input int h, input logic [63:0] img,
                           input int mode, input int stall_len, input int abort_after);
    logic [8:0] q[$];
    logic [8:0] e;
    logic [8:0] prev_x;
    bit         prev_hold;
    bit         pend;
    bit         seen;
    bit         tgl;
    bit         done;
    int         total;
    int         idx;
    int         cyc;
    int         fd_due;
    int         stall;

    total = w * h; idx = 0; cyc = 0; fd_due = -1; stall = 0;
    pend = 0; seen = 0; tgl = 1; done = 0; prev_hold = 0; prev_x = '0;
    sel = s;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        e = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e[3*i+j] = img[(r-2+i)*w + (c-2+j)];
        q.push_back(e);
      end
    end

    while (!done) begin
      @(posedge clk); #1;
      if (stall_len > 0 && !seen && s_wv) begin
        seen  = 1;
        stall = stall_len;
      end
      if (idx < total) begin
        case (mode)
          0: pv[s] = 1'b1;
          1: begin pv[s] = tgl; tgl = !tgl; end
          default: pv[s] = 1'($urandom_range(0, 1));
        endcase
        pin[s] = img[idx];
      end else begin
        pv[s]  = 1'b0;
        pin[s] = 1'($urandom_range(0, 1));
      end
      if (stall > 0) wr[s] = 1'b0;
      else if (mode == 2) wr[s] = ($urandom_range(0, 3) != 0);
      else wr[s] = 1'b1;

      @(negedge clk);
      cyc++;
      check("pix_ready", 32'(s_pr), 32'(!s_wv || wr[s]));
      if (pend) check("win_latency", 32'(s_wv), 32'd1);
      if (prev_hold) begin
        check("hold_x", 32'(s_x), 32'(prev_x));
        check("hold_valid", 32'(s_wv), 32'd1);
      end
      if (stall > 0) begin
        check("stall_pix_ready", 32'(s_pr), 32'd0);
        stall--;
      end
      check("frame_done", 32'(s_fd), 32'(cyc == fd_due));
      if (cyc == fd_due) check("done_with_last_win", 32'(s_wv), 32'd1);
      if (s_wv && wr[s]) begin
        if (q.size() == 0) check("extra_win", 32'(s_wv), 32'd0);
        else begin
          e = q.pop_front();
          check("win_data", 32'(s_x), 32'(e));
        end
      end
      prev_hold = s_wv && !wr[s];
      prev_x    = s_x;
      pend      = 0;
      if (pv[s] && s_pr) begin
        if ((idx / w) >= 2 && (idx % w) >= 2) pend = 1;
        idx++;
        if (idx == total) fd_due = cyc + 1;
      end
      if (abort_after > 0 && idx == abort_after) done = 1;
      else if (idx == total && q.size() == 0 && cyc > fd_due) done = 1;
      else if (cyc > 4000) begin
        check("timeout_cycles", 32'(cyc), 32'd4000);
        done = 1;
      end
    end
    if (abort_after == 0) check("windows_missing", 32'(q.size()), 32'd0);
  endtask

  logic [63:0] img_diag;
  logic [63:0] img_ones;
  logic [63:0] img_zero;
  logic [63:0] img_alt3;
  logic [63:0] img_rnd;

  initial begin
    rst_n = 1'b0;
    pin   = '0;
    pv    = '0;
    wr    = 3'b111;
    sel   = 0;
    img_diag = '0;
    for (int r = 0; r < 4; r++) img_diag[r*4 + r] = 1'b1;
    img_ones = '1;
    img_zero = '0;
    img_alt3 = '0;
    for (int k = 0; k < 9; k += 2) img_alt3[k] = 1'b1;

    #12;
    check_idle(0);
    check_idle(1);
    check_idle(2);
    rst_n = 1'b1;

    run_frame(0, 4, 4, img_diag, 0, 0, 0);
    run_frame(0, 4, 4, img_diag, 0, 5, 0);
    run_frame(1, 8, 8, img_ones, 1, 0, 0);
    run_frame(0, 4, 4, img_ones, 0, 0, 0);
    run_frame(0, 4, 4, img_zero, 0, 0, 0);

    run_frame(0, 4, 4, img_diag, 0, 0, 9);
    @(posedge clk); #1;
    pv[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle(0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    run_frame(0, 4, 4, img_diag, 0, 0, 0);

    run_frame(2, 3, 3, img_alt3, 0, 0, 0);

    for (int t = 0; t < 3; t++) begin
      img_rnd = {$urandom, $urandom};
      run_frame(1, 8, 8, img_rnd, 2, 0, 0);
    end
    for (int t = 0; t < 2; t++) begin
      img_rnd = {$urandom, $urandom};
      run_frame(0, 4, 4, img_rnd, 2, 0, 0);
      run_frame(2, 3, 3, img_rnd, 2, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
